playback_controller: RTL and testbench
======================================

PLAYBACK_CONTROLLER -- requirements
Module: playback_controller

Interface
REQ-001 Parameter RAMP_TICKS, default 4: seek ticks spent at slow step before switching to fast step.
REQ-002 Parameter FF_SLOW, default 8; FF_FAST, default 15: forward seek steps, seconds per tick.
REQ-003 Parameter RW_SLOW, default 10; RW_FAST, default 30: rewind step magnitudes, seconds per tick.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 reset  input  1  synchronous, active-low; sampled on the rising edge of clk.
REQ-006 tick  input  1  one-cycle 1 Hz enable pulse.
REQ-007 play_pause  input  1  one-cycle pulse; toggles play/pause.
REQ-008 stop  input  1  one-cycle pulse; stops and rewinds to 0:00.
REQ-009 ff_hold  input  1  level; fast-forward while high.
REQ-010 rw_hold  input  1  level; rewind while high.
REQ-011 song_end  input  1  level from timer compare; elapsed time >= song length.
REQ-012 at_zero  input  1  level from timer; elapsed time == 0:00.
REQ-013 count  output  1  one-cycle pulse; timer adds adder on this cycle.
REQ-014 adder  output  9  signed step applied by timer; two's complement.
REQ-015 timer_reset  output  1  one-cycle pulse; clears timer to 0:00.
REQ-016 state  output  3  encoded FSM state: STOPPED=0, PLAYING=1, PAUSED=2, FFWD=3, RWND=4.
REQ-017 playing  output  1  high in PLAYING, FFWD and RWND.

Function
REQ-018 All outputs SHALL be registered; state transitions and output responses SHALL appear on the edge after the inputs are sampled.
REQ-019 Input priority per cycle SHALL be: stop > song_end > play_pause > seek holds.
REQ-020 STOPPED: play_pause -> PLAYING; seek holds ignored.
REQ-021 PLAYING: play_pause -> PAUSED; ff_hold only -> FFWD; rw_hold only -> RWND; song_end -> STOPPED.
REQ-022 PAUSED: play_pause -> PLAYING; ff_hold only -> FFWD; rw_hold only -> RWND.
REQ-023 Seek entry SHALL record the origin state (PLAYING or PAUSED) in a resume flag; release of the hold SHALL return to that origin.
REQ-024 ff_hold and rw_hold both high SHALL be ignored in PLAYING/PAUSED; in FFWD/RWND, deassertion of the active hold alone SHALL end the seek.
REQ-025 play_pause during FFWD/RWND SHALL toggle the resume flag without leaving the seek.
REQ-026 stop in any state SHALL go to STOPPED and pulse timer_reset for one cycle; reset SHALL NOT pulse timer_reset.
REQ-027 song_end in PLAYING or FFWD SHALL go to STOPPED with a one-cycle timer_reset pulse; song_end in PAUSED or RWND SHALL be ignored.
REQ-028 at_zero in RWND SHALL end the seek and return to the origin state; count SHALL NOT pulse on that tick.
REQ-029 count SHALL pulse one cycle after a tick sampled in PLAYING, FFWD or RWND; never in STOPPED or PAUSED.
REQ-030 adder SHALL be +1 in PLAYING; +FF_SLOW/+FF_FAST in FFWD; -RW_SLOW/-RW_FAST in RWND; +0 in STOPPED and PAUSED.
REQ-031 adder SHALL update in the same cycle as the state change; adder is stable whenever count is high.
REQ-032 A ramp counter SHALL clear on seek entry and increment per tick in FFWD/RWND, saturating at RAMP_TICKS.
REQ-033 Slow step applies while ramp counter < RAMP_TICKS; fast step applies once it reaches RAMP_TICKS.
REQ-034 tick coincident with a transition SHALL be evaluated in the old state: count pulses with the old state's adder.
REQ-035 Parameters SHALL fit in 9-bit signed; RW_FAST <= 255.

Reset
REQ-036 reset low on an edge SHALL force: state=STOPPED, count=0, timer_reset=0, adder=0, playing=0, ramp counter=0, resume flag=PAUSED.
REQ-037 Reset mid-seek or mid-play SHALL abandon the operation without any count or timer_reset pulse.

Verification
REQ-038 Reset, play_pause, 3 ticks -> state=1; 3 count pulses with adder=+1.
REQ-039 In PLAYING, hold ff_hold for 6 ticks -> 4 counts at +8, 2 at +15; release -> state=1, adder=+1.
REQ-040 From PAUSED, hold rw_hold; at_zero after 2 ticks -> counts at -10, -10; state=2; adder=0; no count on at_zero tick.
REQ-041 In PLAYING, raise song_end -> next cycle state=0, timer_reset high for exactly 1 cycle; stop and play_pause pulsed together -> STOPPED.
REQ-042 ff_hold and rw_hold together in PLAYING -> state remains 1; reset low mid-FFWD -> all outputs zero, state=0, no timer_reset pulse.

Source files
------------

// File: rtl/playback_controller.sv
// Playback controller: play/pause/stop FSM with ramped fast-forward and rewind.
// Drives the elapsed-time timer through count/adder/timer_reset. All outputs are registered.
//
// state   | meaning
// --------+-----------------------------------------------------------
// STOPPED | idle at 0:00, no counting
// PLAYING | normal playback, +1 s per tick
// PAUSED  | holding position, no counting
// FFWD    | forward seek, slow step then fast step after RAMP_TICKS
// RWND    | reverse seek, slow step then fast step, ends at 0:00
module playback_controller #(
    parameter int RAMP_TICKS = 4,
    parameter int FF_SLOW    = 8,
    parameter int FF_FAST    = 15,
    parameter int RW_SLOW    = 10,
    parameter int RW_FAST    = 30
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       play_pause,
    input  logic       stop,
    input  logic       ff_hold,
    input  logic       rw_hold,
    input  logic       song_end,
    input  logic       at_zero,
    output logic       count,
    output logic [8:0] adder,
    output logic       timer_reset,
    output logic [2:0] state,
    output logic       playing
);

    typedef enum logic [2:0] {
        STOPPED = 3'd0,
        PLAYING = 3'd1,
        PAUSED  = 3'd2,
        FFWD    = 3'd3,
        RWND    = 3'd4
    } state_t;

    localparam int RCW = (RAMP_TICKS < 1) ? 1 : $clog2(RAMP_TICKS + 1);
    localparam logic [RCW-1:0] RAMP_MAX = RCW'(RAMP_TICKS);

    localparam logic [8:0] STEP_PLAY    = 9'd1;
    localparam logic [8:0] STEP_FF_SLOW = 9'(FF_SLOW);
    localparam logic [8:0] STEP_FF_FAST = 9'(FF_FAST);
    localparam logic [8:0] STEP_RW_SLOW = 9'(-RW_SLOW);
    localparam logic [8:0] STEP_RW_FAST = 9'(-RW_FAST);

    state_t         st_q, st_n;
    logic           resume_play_q, resume_play_n;
    logic [RCW-1:0] ramp_q, ramp_n;
    logic           count_n, timer_reset_n;
    logic [8:0]     adder_n;
    logic           counting, in_seek;
    state_t         origin;

    // Step the timer would apply in a given state with a given ramp position.
    function automatic logic [8:0] step_for(input state_t s, input logic [RCW-1:0] r);
        logic [8:0] v;
        v = 9'd0;
        case (s)
            PLAYING: v = STEP_PLAY;
            FFWD:    v = (r < RAMP_MAX) ? STEP_FF_SLOW : STEP_FF_FAST;
            RWND:    v = (r < RAMP_MAX) ? STEP_RW_SLOW : STEP_RW_FAST;
            default: v = 9'd0;
        endcase
        return v;
    endfunction

    // Next-state decode with priority stop > song_end > play_pause > seek holds.
    always_comb begin
        st_n          = st_q;
        resume_play_n = resume_play_q;
        ramp_n        = ramp_q;
        timer_reset_n = 1'b0;
        counting      = (st_q == PLAYING) || (st_q == FFWD) || (st_q == RWND);
        in_seek       = (st_q == FFWD) || (st_q == RWND);
        origin        = resume_play_q ? PLAYING : PAUSED;

        if (tick && in_seek && (ramp_q < RAMP_MAX))
            ramp_n = ramp_q + 1'b1;

        if (stop) begin
            st_n          = STOPPED;
            timer_reset_n = 1'b1;
        end else if (song_end && ((st_q == PLAYING) || (st_q == FFWD))) begin
            st_n          = STOPPED;
            timer_reset_n = 1'b1;
        end else begin
            case (st_q)
                STOPPED: begin
                    if (play_pause) st_n = PLAYING;
                end
                PLAYING, PAUSED: begin
                    if (play_pause) begin
                        st_n = (st_q == PLAYING) ? PAUSED : PLAYING;
                    end else if (ff_hold && !rw_hold) begin
                        st_n          = FFWD;
                        resume_play_n = (st_q == PLAYING);
                        ramp_n        = '0;
                    end else if (rw_hold && !ff_hold) begin
                        st_n          = RWND;
                        resume_play_n = (st_q == PLAYING);
                        ramp_n        = '0;
                    end
                end
                FFWD: begin
                    if (play_pause)    resume_play_n = !resume_play_q;
                    else if (!ff_hold) st_n = origin;
                end
                RWND: begin
                    if (at_zero)         st_n = origin;
                    else if (play_pause) resume_play_n = !resume_play_q;
                    else if (!rw_hold)   st_n = origin;
                end
                default: st_n = STOPPED;
            endcase
        end

        // A tick is charged to the state it was sampled in; hitting 0:00 while rewinding is not counted.
        count_n = tick && counting && !((st_q == RWND) && at_zero);
        adder_n = count_n ? step_for(st_q, ramp_q) : step_for(st_n, ramp_n);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            st_q          <= STOPPED;
            resume_play_q <= 1'b0;
            ramp_q        <= '0;
            count         <= 1'b0;
            adder         <= 9'd0;
            timer_reset   <= 1'b0;
            playing       <= 1'b0;
        end else begin
            st_q          <= st_n;
            resume_play_q <= resume_play_n;
            ramp_q        <= ramp_n;
            count         <= count_n;
            adder         <= adder_n;
            timer_reset   <= timer_reset_n;
            playing       <= (st_n == PLAYING) || (st_n == FFWD) || (st_n == RWND);
        end
    end

    assign state = st_q;

endmodule

// File: tb/tb_playback_controller.sv
// Directed bench for playback_controller: play, ramped seeks, stop/song_end, reset behaviour.
module tb_playback_controller;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       tick = 1'b0, play_pause = 1'b0, stop = 1'b0;
    logic       ff_hold = 1'b0, rw_hold = 1'b0, song_end = 1'b0, at_zero = 1'b0;
    logic       count, timer_reset, playing;
    logic [8:0] adder;
    logic [2:0] state;

    int tests = 0;
    int fails = 0;

    playback_controller dut (
        .clk(clk), .reset(reset), .tick(tick), .play_pause(play_pause), .stop(stop),
        .ff_hold(ff_hold), .rw_hold(rw_hold), .song_end(song_end), .at_zero(at_zero),
        .count(count), .adder(adder), .timer_reset(timer_reset), .state(state), .playing(playing)
    );

    always #5 clk = ~clk;

    // Advance one clock, settle, then drop the one-cycle pulse inputs.
    task automatic cyc();
        @(posedge clk);
        #1;
        tick = 1'b0;
        play_pause = 1'b0;
        stop = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        cyc();
        cyc();
        tests++; if (state !== 3'd0)       begin fails++; $display("FAIL reset_state got %0d want 0", state); end
        tests++; if (count !== 1'b0)       begin fails++; $display("FAIL reset_count got %b want 0", count); end
        tests++; if (adder !== 9'd0)       begin fails++; $display("FAIL reset_adder got %h want 000", adder); end
        tests++; if (timer_reset !== 1'b0) begin fails++; $display("FAIL reset_timer_reset got %b want 0", timer_reset); end
        tests++; if (playing !== 1'b0)     begin fails++; $display("FAIL reset_playing got %b want 0", playing); end
        reset = 1'b1;
        cyc();
    endtask

    task automatic test_play();
        int npulse;
        npulse = 0;
        play_pause = 1'b1;
        cyc();
        tests++; if (state !== 3'd1 || playing !== 1'b1) begin fails++; $display("FAIL play_state got %0d/%b want 1/1", state, playing); end
        tests++; if (adder !== 9'd1 || count !== 1'b0)   begin fails++; $display("FAIL play_adder got %h/%b want 001/0", adder, count); end
        for (int i = 0; i < 3; i++) begin
            tick = 1'b1;
            cyc();
            if (count === 1'b1 && adder === 9'd1) npulse++;
            cyc();
            tests++; if (count !== 1'b0) begin fails++; $display("FAIL play_count_width got %b want 0", count); end
        end
        tests++; if (npulse != 3) begin fails++; $display("FAIL play_pulses got %0d want 3", npulse); end
    endtask

    task automatic test_ffwd();
        logic [8:0] exp_ff [6];
        exp_ff = '{9'd8, 9'd8, 9'd8, 9'd8, 9'd15, 9'd15};
        ff_hold = 1'b1;
        cyc();
        tests++; if (state !== 3'd3 || adder !== 9'd8) begin fails++; $display("FAIL ff_entry got %0d/%h want 3/008", state, adder); end
        for (int i = 0; i < 6; i++) begin
            tick = 1'b1;
            cyc();
            tests++;
            if (count !== 1'b1 || adder !== exp_ff[i]) begin
                fails++; $display("FAIL ff_tick%0d got count=%b adder=%h want 1/%h", i, count, adder, exp_ff[i]);
            end
            cyc();
        end
        ff_hold = 1'b0;
        cyc();
        tests++; if (state !== 3'd1 || adder !== 9'd1) begin fails++; $display("FAIL ff_release got %0d/%h want 1/001", state, adder); end
    endtask

    task automatic test_rwnd_fast();
        logic [8:0] exp_rw [5];
        exp_rw = '{9'h1F6, 9'h1F6, 9'h1F6, 9'h1F6, 9'h1E2};
        rw_hold = 1'b1;
        cyc();
        tests++; if (state !== 3'd4 || adder !== 9'h1F6) begin fails++; $display("FAIL rw_entry got %0d/%h want 4/1f6", state, adder); end
        song_end = 1'b1;
        cyc();
        tests++; if (state !== 3'd4 || timer_reset !== 1'b0) begin fails++; $display("FAIL rw_song_end got %0d/%b want 4/0", state, timer_reset); end
        song_end = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick = 1'b1;
            cyc();
            tests++;
            if (count !== 1'b1 || adder !== exp_rw[i]) begin
                fails++; $display("FAIL rw_tick%0d got count=%b adder=%h want 1/%h", i, count, adder, exp_rw[i]);
            end
            cyc();
        end
        rw_hold = 1'b0;
        cyc();
        tests++; if (state !== 3'd1 || adder !== 9'd1) begin fails++; $display("FAIL rw_release got %0d/%h want 1/001", state, adder); end
    endtask

    task automatic test_rwnd_at_zero();
        play_pause = 1'b1;
        cyc();
        tests++; if (state !== 3'd2 || adder !== 9'd0 || playing !== 1'b0) begin fails++; $display("FAIL pause got %0d/%h/%b want 2/000/0", state, adder, playing); end
        rw_hold = 1'b1;
        cyc();
        tests++; if (state !== 3'd4 || playing !== 1'b1) begin fails++; $display("FAIL rz_entry got %0d/%b want 4/1", state, playing); end
        for (int i = 0; i < 2; i++) begin
            tick = 1'b1;
            cyc();
            tests++; if (count !== 1'b1 || adder !== 9'h1F6) begin fails++; $display("FAIL rz_tick%0d got %b/%h want 1/1f6", i, count, adder); end
            cyc();
        end
        at_zero = 1'b1;
        tick = 1'b1;
        cyc();
        tests++; if (state !== 3'd2) begin fails++; $display("FAIL rz_exit_state got %0d want 2", state); end
        tests++; if (count !== 1'b0 || adder !== 9'd0) begin fails++; $display("FAIL rz_exit_count got %b/%h want 0/000", count, adder); end
        rw_hold = 1'b0;
        at_zero = 1'b0;
        cyc();
        tests++; if (state !== 3'd2) begin fails++; $display("FAIL rz_settle got %0d want 2", state); end
    endtask

    task automatic test_song_end();
        song_end = 1'b1;
        cyc();
        tests++; if (state !== 3'd2 || timer_reset !== 1'b0) begin fails++; $display("FAIL se_paused got %0d/%b want 2/0", state, timer_reset); end
        song_end = 1'b0;
        play_pause = 1'b1;
        cyc();
        tests++; if (state !== 3'd1) begin fails++; $display("FAIL se_resume got %0d want 1", state); end
        song_end = 1'b1;
        cyc();
        tests++; if (state !== 3'd0 || timer_reset !== 1'b1) begin fails++; $display("FAIL se_stop got %0d/%b want 0/1", state, timer_reset); end
        song_end = 1'b0;
        cyc();
        tests++; if (timer_reset !== 1'b0 || state !== 3'd0) begin fails++; $display("FAIL se_pulse_width got %b/%0d want 0/0", timer_reset, state); end
    endtask

    task automatic test_stop_priority();
        play_pause = 1'b1;
        cyc();
        ff_hold = 1'b1;
        cyc();
        tests++; if (state !== 3'd3) begin fails++; $display("FAIL sp_ffwd got %0d want 3", state); end
        stop = 1'b1;
        play_pause = 1'b1;
        cyc();
        tests++; if (state !== 3'd0 || timer_reset !== 1'b1 || playing !== 1'b0) begin fails++; $display("FAIL sp_stop got %0d/%b/%b want 0/1/0", state, timer_reset, playing); end
        ff_hold = 1'b0;
        cyc();
        tests++; if (timer_reset !== 1'b0 || state !== 3'd0) begin fails++; $display("FAIL sp_pulse_width got %b/%0d want 0/0", timer_reset, state); end
        ff_hold = 1'b1;
        cyc();
        tests++; if (state !== 3'd0) begin fails++; $display("FAIL sp_hold_ignored got %0d want 0", state); end
        ff_hold = 1'b0;
    endtask

    task automatic test_both_holds();
        play_pause = 1'b1;
        cyc();
        ff_hold = 1'b1;
        rw_hold = 1'b1;
        cyc();
        cyc();
        tests++; if (state !== 3'd1 || adder !== 9'd1) begin fails++; $display("FAIL bh_state got %0d/%h want 1/001", state, adder); end
        ff_hold = 1'b0;
        rw_hold = 1'b0;
        cyc();
    endtask

    task automatic test_resume_toggle();
        ff_hold = 1'b1;
        cyc();
        play_pause = 1'b1;
        cyc();
        tests++; if (state !== 3'd3) begin fails++; $display("FAIL rt_stay got %0d want 3", state); end
        ff_hold = 1'b0;
        cyc();
        tests++; if (state !== 3'd2 || playing !== 1'b0 || adder !== 9'd0) begin fails++; $display("FAIL rt_return got %0d/%b/%h want 2/0/000", state, playing, adder); end
    endtask

    task automatic test_reset_mid_seek();
        play_pause = 1'b1;
        cyc();
        ff_hold = 1'b1;
        cyc();
        tick = 1'b1;
        reset = 1'b0;
        cyc();
        tests++; if (state !== 3'd0 || count !== 1'b0 || adder !== 9'd0) begin fails++; $display("FAIL rm_core got %0d/%b/%h want 0/0/000", state, count, adder); end
        tests++; if (timer_reset !== 1'b0 || playing !== 1'b0) begin fails++; $display("FAIL rm_flags got %b/%b want 0/0", timer_reset, playing); end
        ff_hold = 1'b0;
        reset = 1'b1;
        cyc();
        tests++; if (timer_reset !== 1'b0 || count !== 1'b0 || state !== 3'd0) begin fails++; $display("FAIL rm_after got %b/%b/%0d want 0/0/0", timer_reset, count, state); end
    endtask

    initial begin
        test_reset();
        test_play();
        test_ffwd();
        test_rwnd_fast();
        test_rwnd_at_zero();
        test_song_end();
        test_stop_priority();
        test_both_holds();
        test_resume_toggle();
        test_reset_mid_seek();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
